// File: rtl/ftdi_stream_tester.sv
// Traffic generator and self-synchronising checker for the 245-FIFO user-side stream.
// Increment or PRBS8 byte sequence. Lane 0 of each word carries the earliest byte.
module ftdi_stream_tester #(
  parameter int TX_DEXP = 2,
  parameter int RX_DEXP = 0,
  parameter int TIMEOUT = 5000000,
  parameter int CNT_W   = 32
)(
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     mode,
  input  logic                     tx_en,
  input  logic                     clr,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [(8<<TX_DEXP)-1:0]  tx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  input  logic [(8<<RX_DEXP)-1:0]  rx_data,
  output logic                     locked,
  output logic                     err,
  output logic [15:0]              err_cnt,
  output logic [CNT_W-1:0]         tx_bytes,
  output logic [CNT_W-1:0]         rx_bytes
);
  localparam int TXB = 1 << TX_DEXP;
  localparam int RXB = 1 << RX_DEXP;
  localparam int IW  = $clog2(TIMEOUT + 1);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  function automatic logic [7:0] f(input logic m, input logic [7:0] s);
    return m ? {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]} : s + 8'd1;
  endfunction

  function automatic logic [7:0] seed(input logic m);
    return m ? 8'h01 : 8'h00;
  endfunction

  // ---------------- generator ----------------
  logic [7:0]           base;
  logic                 gen_mode, mode_r;
  logic [TXB-1:0][7:0]  tx_lane;
  logic                 hs;

  assign hs = tx_valid & tx_ready;

  for (genvar k = 0; k < TXB; k++) begin : g_tx_lane
    if (k == 0) begin : g_first
      assign tx_lane[k] = base;
    end else begin : g_next
      assign tx_lane[k] = f(gen_mode, tx_lane[k-1]);
    end
  end
  assign tx_data = tx_lane;

  // gen_mode only follows mode at a word boundary so a held word never changes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_valid <= 1'b0;
      base     <= 8'h00;
      gen_mode <= 1'b0;
      mode_r   <= 1'b0;
    end else begin
      if (!tx_valid || tx_ready) tx_valid <= tx_en;
      if (mode != gen_mode && (!tx_valid || hs)) begin
        base     <= seed(mode);
        gen_mode <= mode;
      end else if (hs) begin
        base <= f(gen_mode, tx_lane[TXB-1]);
      end
      mode_r <= mode;
    end
  end

  // ---------------- checker ----------------
  logic [RXB-1:0][7:0]  rx_lane;
  logic [RXB-1:0]       mis;
  logic [7:0]           last;
  logic                 acc, mode_chg, lock_eff;
  state_t               state, state_nxt;
  logic [IW-1:0]        idle, idle_nxt;
  logic [16:0]          nerr, err_sum;
  logic [15:0]          err_nxt;

  assign rx_lane  = rx_data;
  assign acc      = rx_valid & rx_ready;
  assign mode_chg = (mode != mode_r);
  assign lock_eff = (state == LOCKED) && !mode_chg;

  // prediction is always taken from received bytes, so the checker re-syncs itself
  for (genvar k = 0; k < RXB; k++) begin : g_rx_lane
    if (k == 0) begin : g_first
      assign mis[k] = lock_eff && (rx_lane[k] != f(mode, last));
    end else begin : g_next
      assign mis[k] = (rx_lane[k] != f(mode, rx_lane[k-1]));
    end
  end

  always_comb begin
    nerr = '0;
    for (int k = 0; k < RXB; k++) nerr = nerr + 17'(mis[k]);
    err_sum = {1'b0, err_cnt} + nerr;
    err_nxt = err_cnt;
    if (clr)      err_nxt = 16'h0000;
    else if (acc) err_nxt = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_comb begin
    state_nxt = state;
    idle_nxt  = idle;
    if (acc) begin
      state_nxt = LOCKED;
      idle_nxt  = IW'(TIMEOUT);
    end else if (idle != '0) begin
      idle_nxt = idle - IW'(1);
      if (idle == IW'(1)) state_nxt = UNLOCKED;
    end
    if (mode_chg) state_nxt = UNLOCKED;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= UNLOCKED;
      idle     <= '0;
      last     <= 8'h00;
      rx_ready <= 1'b0;
      err_cnt  <= 16'h0000;
      err      <= 1'b0;
      tx_bytes <= '0;
      rx_bytes <= '0;
    end else begin
      state    <= state_nxt;
      idle     <= idle_nxt;
      rx_ready <= 1'b1;
      err_cnt  <= err_nxt;
      err      <= (err_nxt != 16'h0000);
      if (acc) last <= rx_lane[RXB-1];
      if (clr)      tx_bytes <= '0;
      else if (hs)  tx_bytes <= tx_bytes + CNT_W'(TXB);
      if (clr)      rx_bytes <= '0;
      else if (acc) rx_bytes <= rx_bytes + CNT_W'(RXB);
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_ftdi_stream_tester.sv
// Directed bench: one 32b-TX/8b-RX instance with short timeout, one 32b/32b PRBS loopback instance.
module tb_ftdi_stream_tester;
  logic        clk = 1'b0;
  logic        rstn, mode, tx_en, clr, tx_ready, rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid, rx_ready, locked, err;
  logic [31:0] tx_data, tx_bytes, rx_bytes;
  logic [15:0] err_cnt;

  logic        mode2, tx_en2, tx_valid2, rx_ready2, locked2, err2;
  logic [31:0] tx_data2, tx_bytes2, rx_bytes2;
  logic [15:0] err_cnt2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ftdi_stream_tester #(.TX_DEXP(2), .RX_DEXP(0), .TIMEOUT(10), .CNT_W(32)) dut (
    .clk(clk), .rstn(rstn), .mode(mode), .tx_en(tx_en), .clr(clr),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .locked(locked), .err(err), .err_cnt(err_cnt),
    .tx_bytes(tx_bytes), .rx_bytes(rx_bytes)
  );

  ftdi_stream_tester #(.TX_DEXP(2), .RX_DEXP(2), .TIMEOUT(10), .CNT_W(32)) dut2 (
    .clk(clk), .rstn(rstn), .mode(mode2), .tx_en(tx_en2), .clr(clr),
    .tx_valid(tx_valid2), .tx_ready(rx_ready2), .tx_data(tx_data2),
    .rx_valid(tx_valid2), .rx_ready(rx_ready2), .rx_data(tx_data2),
    .locked(locked2), .err(err2), .err_cnt(err_cnt2),
    .tx_bytes(tx_bytes2), .rx_bytes(rx_bytes2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; mode = 1'b0; tx_en = 1'b0; clr = 1'b0; tx_ready = 1'b0;
    rx_valid = 1'b0; rx_data = 8'h00; mode2 = 1'b1; tx_en2 = 1'b0;
    tick(); tick();
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rst_tx_valid got %b want 0", tx_valid); end
    total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL rst_rx_ready got %b want 0", rx_ready); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL rst_locked got %b want 0", locked); end
    total++; if (err_cnt !== 16'h0 || err !== 1'b0) begin bad++; $display("FAIL rst_err got %h/%b want 0/0", err_cnt, err); end
    total++; if (tx_bytes !== 32'h0 || rx_bytes !== 32'h0) begin bad++; $display("FAIL rst_bytes got %h/%h want 0/0", tx_bytes, rx_bytes); end
    rstn = 1'b1;
    tick();
    total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL rel_rx_ready got %b want 1", rx_ready); end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rel_tx_valid got %b want 0", tx_valid); end
  endtask

  task automatic test_tx_incr();
    logic [31:0] w;
    tx_en = 1'b1; tx_ready = 1'b1;
    tick();
    for (int i = 0; i < 64; i++) begin
      for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'(4*i + k);
      total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL incr_valid[%0d] got %b want 1", i, tx_valid); end
      total++; if (tx_data !== w) begin bad++; $display("FAIL incr_data[%0d] got %h want %h", i, tx_data, w); end
      total++; if (tx_bytes !== 32'(4*i)) begin bad++; $display("FAIL incr_bytes[%0d] got %0d want %0d", i, tx_bytes, 4*i); end
      tick();
    end
    total++; if (tx_data !== 32'h03020100) begin bad++; $display("FAIL incr_wrap got %h want 03020100", tx_data); end
    total++; if (tx_bytes !== 32'd256) begin bad++; $display("FAIL incr_bytes256 got %0d want 256", tx_bytes); end
  endtask

  task automatic test_tx_stall();
    tick(); tick();
    tx_ready = 1'b0;
    total++; if (tx_data !== 32'h0B0A0908) begin bad++; $display("FAIL stall_word got %h want 0b0a0908", tx_data); end
    for (int c = 0; c < 5; c++) begin
      if (c == 2) tx_en = 1'b0;
      tick();
      total++; if (tx_valid !== 1'b1 || tx_data !== 32'h0B0A0908) begin bad++; $display("FAIL stall_hold[%0d] got %b/%h want 1/0b0a0908", c, tx_valid, tx_data); end
      total++; if (tx_bytes !== 32'd264) begin bad++; $display("FAIL stall_bytes[%0d] got %0d want 264", c, tx_bytes); end
    end
    tx_ready = 1'b1;
    tick();
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL stall_drop got %b want 0", tx_valid); end
    total++; if (tx_bytes !== 32'd268) begin bad++; $display("FAIL stall_hs got %0d want 268", tx_bytes); end
    tick();
    total++; if (tx_bytes !== 32'd268 || tx_valid !== 1'b0) begin bad++; $display("FAIL stall_once got %0d/%b want 268/0", tx_bytes, tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_rx();
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL rx_prelock got %b want 0", locked); end
    send(8'd0);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL rx_lock got %b want 1", locked); end
    for (int b = 1; b < 10; b++) send(8'(b));
    total++; if (err_cnt !== 16'd0) begin bad++; $display("FAIL rx_clean got %0d want 0", err_cnt); end
    total++; if (rx_bytes !== 32'd10) begin bad++; $display("FAIL rx_bytes10 got %0d want 10", rx_bytes); end
    send(8'd10); send(8'd11); send(8'h55); send(8'd13); send(8'd14);
    total++; if (err_cnt !== 16'd2) begin bad++; $display("FAIL rx_corrupt got %0d want 2", err_cnt); end
    send(8'd15); send(8'd17); send(8'd18);
    total++; if (err_cnt !== 16'd3) begin bad++; $display("FAIL rx_drop got %0d want 3", err_cnt); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL rx_err got %b want 1", err); end
    total++; if (rx_bytes !== 32'd18) begin bad++; $display("FAIL rx_bytes18 got %0d want 18", rx_bytes); end
  endtask

  task automatic test_timeout();
    clr = 1'b1; tick(); clr = 1'b0;
    total++; if (err_cnt !== 16'd0 || err !== 1'b0 || rx_bytes !== 32'd0 || tx_bytes !== 32'd0) begin bad++; $display("FAIL clr got %0d/%b/%0d/%0d want 0/0/0/0", err_cnt, err, rx_bytes, tx_bytes); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL clr_lock got %b want 1", locked); end
    for (int b = 19; b < 24; b++) send(8'(b));
    for (int j = 1; j <= 10; j++) begin
      tick();
      if (j == 9) begin
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL to_early got %b want 1", locked); end
      end
      if (j == 10) begin
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL to_unlock got %b want 0", locked); end
      end
    end
    send(8'h80); send(8'h81);
    total++; if (err_cnt !== 16'd0 || locked !== 1'b1) begin bad++; $display("FAIL to_resume got %0d/%b want 0/1", err_cnt, locked); end
    rx_data = 8'h82; rx_valid = 1'b1; clr = 1'b1;
    tick();
    rx_valid = 1'b0; clr = 1'b0;
    total++; if (rx_bytes !== 32'd0) begin bad++; $display("FAIL clr_win got %0d want 0", rx_bytes); end
    send(8'h83);
    total++; if (rx_bytes !== 32'd1 || err_cnt !== 16'd0) begin bad++; $display("FAIL clr_last got %0d/%0d want 1/0", rx_bytes, err_cnt); end
  endtask

  task automatic test_loopback();
    int  n = 0;
    logic zseen = 1'b0;
    tx_en2 = 1'b1;
    tick();
    while (!tx_valid2 && n < 10) begin tick(); n++; end
    total++; if (tx_valid2 !== 1'b1) begin bad++; $display("FAIL lb_start got %b want 1", tx_valid2); end
    for (int w = 0; w < 1000; w++) begin
      if (w == 0) begin
        total++; if (tx_data2 !== 32'h08040201) begin bad++; $display("FAIL lb_word0 got %h want 08040201", tx_data2); end
      end
      if (w == 1) begin
        total++; if (tx_data2 !== 32'h8E472311) begin bad++; $display("FAIL lb_word1 got %h want 8e472311", tx_data2); end
      end
      for (int k = 0; k < 4; k++) if (tx_data2[8*k +: 8] == 8'h00 || !tx_valid2) zseen = 1'b1;
      tick();
    end
    total++; if (zseen !== 1'b0) begin bad++; $display("FAIL lb_zero got %b want 0", zseen); end
    total++; if (err_cnt2 !== 16'd0 || err2 !== 1'b0) begin bad++; $display("FAIL lb_err got %0d/%b want 0/0", err_cnt2, err2); end
    total++; if (rx_bytes2 !== 32'd4000 || tx_bytes2 !== 32'd4000) begin bad++; $display("FAIL lb_bytes got %0d/%0d want 4000/4000", rx_bytes2, tx_bytes2); end
    total++; if (locked2 !== 1'b1) begin bad++; $display("FAIL lb_lock got %b want 1", locked2); end
    tx_en2 = 1'b0;
  endtask

  task automatic test_reset_mid();
    tx_en = 1'b1; tx_ready = 1'b0;
    tick();
    total++; if (tx_valid !== 1'b1 || tx_data !== 32'h0F0E0D0C) begin bad++; $display("FAIL mid_pre got %b/%h want 1/0f0e0d0c", tx_valid, tx_data); end
    tick();
    rstn = 1'b0;
    #1;
    total++; if (tx_valid !== 1'b0 || rx_ready !== 1'b0) begin bad++; $display("FAIL mid_async got %b/%b want 0/0", tx_valid, rx_ready); end
    total++; if (rx_bytes !== 32'd0 || locked !== 1'b0) begin bad++; $display("FAIL mid_clear got %0d/%b want 0/0", rx_bytes, locked); end
    @(posedge clk); #1;
    rstn = 1'b1;
    tick();
    total++; if (tx_valid !== 1'b1 || tx_data !== 32'h03020100) begin bad++; $display("FAIL mid_first got %b/%h want 1/03020100", tx_valid, tx_data); end
    total++; if (tx_bytes !== 32'd0 || rx_bytes !== 32'd0 || err_cnt !== 16'd0) begin bad++; $display("FAIL mid_cnt got %0d/%0d/%0d want 0/0/0", tx_bytes, rx_bytes, err_cnt); end
    total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got %b want 1", rx_ready); end
  endtask

  initial begin
    test_reset();
    test_tx_incr();
    test_tx_stall();
    test_rx();
    test_timeout();
    test_loopback();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ftdi_stream_tester.md
Name: ftdi_stream_tester

Overview:
- Parametrised traffic generator and checker for bring-up and soak testing of the USB 245-FIFO link. It supersedes the fixed 8-bit increment/check logic previously written by hand in board top levels.
- TX side emits a deterministic byte sequence on a valid/ready stream of configurable width.
- RX side self-synchronises to the incoming byte stream, checks it, and reports lock, mismatch counts and byte statistics.
- Sits between the board top and the ftdi_245fifo user-side TX/RX ports, all in the user clock domain.

Parameters:
- TX_DEXP, 2, TX stream width = 8<<TX_DEXP bits (TXB = 1<<TX_DEXP byte lanes).
- RX_DEXP, 0, RX stream width = 8<<RX_DEXP bits (RXB = 1<<RX_DEXP byte lanes).
- TIMEOUT, 5000000, idle clk cycles after the last accepted RX word before the checker unlocks; must be >= 1.
- CNT_W, 32, width of the byte statistic counters.

Ports:
- clk  in  1  user clock; all logic on its rising edge.
- rstn  in  1  asynchronous active-low reset.
- mode  in  1  sequence select: 0 = increment, 1 = PRBS8; quasi-static.
- tx_en  in  1  generator enable.
- clr  in  1  synchronous clear of statistics.
- tx_valid  out  1  TX stream valid.
- tx_ready  in  1  TX stream ready.
- tx_data  out  8<<TX_DEXP  TX word; lane 0 = bits[7:0] is the first byte.
- rx_valid  in  1  RX stream valid.
- rx_ready  out  1  RX stream ready.
- rx_data  in  8<<RX_DEXP  RX word; lane 0 is the first byte.
- locked  out  1  checker synchronised.
- err  out  1  high when err_cnt != 0.
- err_cnt  out  16  saturating count of mismatched bytes.
- tx_bytes  out  CNT_W  bytes sent, wraps modulo 2^CNT_W.
- rx_bytes  out  CNT_W  bytes received, wraps modulo 2^CNT_W.

Behaviour:
- Reset (rstn low, async): tx_valid=0, rx_ready=0, locked=0, err_cnt=0, tx_bytes=0, rx_bytes=0, idle counter=0, checker state UNLOCKED, generator base = seed.
- Seed is 0x00 in increment mode and 0x01 in PRBS mode.
- Sequence function f(s):
  - mode 0: f(s) = s+1 mod 256.
  - mode 1: f(s) = {s[6:0], s[7]^s[5]^s[4]^s[3]} (x^8+x^6+x^5+x^4+1, period 255, 0x00 never occurs).
- Generator:
  - Lane k of tx_data = f^k(base).
  - On each tx_valid & tx_ready handshake, base <= f^TXB(base).
- tx_valid handshake rules:
  - tx_valid is registered and rises one cycle after tx_en is sampled high.
  - Once high, tx_valid and tx_data hold stable until the handshake, even if tx_en falls.
  - tx_valid falls after the handshake only if tx_en is low.
- rx_ready is 0 during reset and 1 from the first clk edge after reset release onward.
- Checker, per accepted word (rx_valid & rx_ready), lanes are evaluated in order 0..RXB-1:
  - Lane k>0 expects f(lane k-1).
  - Lane 0 expects f(last) only when LOCKED. In UNLOCKED, lane 0 is not checked.
  - last <= lane RXB-1; state <= LOCKED; idle counter <= TIMEOUT.
- Prediction always uses received bytes (self-synchronising):
  - a dropped byte counts 1 error;
  - a corrupted byte counts 2 errors (itself and its successor).
- Error counting: err_cnt += number of mismatching lanes in the word, saturating at 0xFFFF.
- Timeout:
  - With no accepted word, the idle counter decrements while nonzero.
  - The transition 1->0 sets state UNLOCKED.
  - An accepted word in the same cycle reloads the counter and stays LOCKED.
- Mode change (mode differs from registered mode_r):
  - mode_r updates and the checker goes UNLOCKED in the same cycle.
  - The generator re-seeds at the next word boundary: immediately if tx_valid=0; otherwise in the cycle of the pending handshake, in place of the normal advance.
- Statistics:
  - tx_bytes += TXB per TX handshake.
  - rx_bytes += RXB per accepted RX word.
  - clr zeroes tx_bytes, rx_bytes and err_cnt. clr wins over a same-cycle increment (result 0). clr does not affect lock, base or last.
- locked = (state == LOCKED); err = (err_cnt != 0). Both are registered and update in the cycle after the causing event.
- Reset asserted mid-transfer: all state returns to reset values immediately; the first word after release is seed-based.

Test Plan:
- TX_DEXP=2, mode 0, tx_en=1, tx_ready=1 -> words 0x03020100, 0x07060504, ...; word 64 = 0x03020100 again; tx_bytes=256 after 64 words.
- Hold tx_ready=0 for 5 cycles, drop tx_en during the stall -> tx_data holds 0x0B0A0908; handshake occurs on ready; tx_valid=0 the next cycle; tx_bytes += 4 only once.
- RX_DEXP=0, mode 0: feed 0..9 -> locked=1 after byte 0, err_cnt=0, rx_bytes=10. Then feed 10,11,0x55,13,14 -> err_cnt=2. Then 15,17,18 -> err_cnt=3, err=1.
- mode 1 loopback (TX out to RX in, TX_DEXP=2, RX_DEXP=2) -> first TX word 0x08040201, second 0x8E472311; err_cnt stays 0 over 1000 words; checker never sees 0x00.
- TIMEOUT=10: feed 5 bytes, idle 10 cycles -> locked falls; resume with 0x80,0x81 -> no error, locked=1. Pulse clr concurrent with an RX accept -> rx_bytes=0.
- Assert rstn low for 1 cycle during a stalled TX word -> tx_valid=0 at once; after release the first word is 0x03020100 and all counters are 0.
